// File: rtl/deser_pkg.sv
// Shared types and helpers for the serial-to-parallel word deserializer.
// Contents: FSM state enum, default word width, storage-index helper.
package deser_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2,
    DONE   = 2'd3
  } deser_state_t;

  localparam int unsigned WORD_W = 16;

  // Storage index for the cnt-th accepted bit of a frame.
  function automatic int unsigned bit_pos(input int unsigned cnt,
                                          input bit          lsb_first,
                                          input int unsigned width = WORD_W);
    return lsb_first ? cnt : (width - 1 - cnt);
  endfunction

endpackage

// File: rtl/shift_capture.sv
// WIDTH-bit capture register with per-bit write enable, clear and index.
// Ports:
//   clk, rst_n  clock, async active-low reset
//   clr         clear all bits (a same-cycle write still lands)
//   we, idx, d  write bit d at position idx
//   q           registered contents
//   q_nxt_c     combinational next value (q after this edge)
module shift_capture #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             we,
  input  logic [IDX_W-1:0] idx,
  input  logic             d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_nxt_c
);

  // Clear first so a frame start can clear and write bit 0 in one edge.
  always_comb begin
    q_nxt_c = clr ? '0 : q;
    if (we) q_nxt_c[idx] = d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= '0;
    else        q <= q_nxt_c;
  end

endmodule

// File: rtl/word_deserializer.sv
// Serial-to-parallel producer: one bit per ser_valid/ser_ready handshake,
// assembles a WIDTH-bit word and pulses load with it on word_out, feeding a
// downstream register's parallel in/load interface.
// Optional feature macro: WORD_DESER_PARITY_EN (adds an even-parity beat
// after the data bits; a mismatch drops the word and pulses frame_err).
// Ports:
//   clk, rst_n            clock, async active-low reset
//   ser_valid, ser_data   serial bit offer and value
//   ser_first             first bit of a frame (sampled on accepted beats)
//   ser_ready             can accept a bit this cycle (low only in DONE)
//   word_out              last completed word, held between loads
//   load                  one-cycle pulse, word_out new in that cycle
//   busy                  frame in progress
//   frame_err             one-cycle pulse on a framing violation
module word_deserializer
  import deser_pkg::*;
#(
  parameter int unsigned WIDTH     = WORD_W,
  parameter bit          LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ser_valid,
  input  logic             ser_data,
  input  logic             ser_first,
  output logic             ser_ready,
  output logic [WIDTH-1:0] word_out,
  output logic             load,
  output logic             busy,
  output logic             frame_err
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned IDX_W = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] FIRST_IDX = IDX_W'(bit_pos(0, LSB_FIRST, WIDTH));
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(WIDTH - 1);

  deser_state_t     state_q, state_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic             cap_clr, cap_we;
  logic [IDX_W-1:0] cap_idx;
  logic [WIDTH-1:0] cap_q, cap_nxt;
  logic             err_c;
  logic             accept_c;

  assign accept_c = ser_valid && ser_ready;

  shift_capture #(
    .WIDTH (WIDTH),
    .IDX_W (IDX_W)
  ) u_capture (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (cap_clr),
    .we      (cap_we),
    .idx     (cap_idx),
    .d       (ser_data),
    .q       (cap_q),
    .q_nxt_c (cap_nxt)
  );

  // Next-state, counter and capture control.
  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    cap_clr   = 1'b0;
    cap_we    = 1'b0;
    cap_idx   = FIRST_IDX;
    err_c     = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept_c) begin
          if (ser_first) begin
            cap_clr   = 1'b1;
            cap_we    = 1'b1;
            cnt_nxt   = CNT_W'(1);
            state_nxt = SHIFT;
          end else begin
            err_c = 1'b1;
          end
        end
      end

      SHIFT: begin
        if (accept_c) begin
          if (ser_first) begin
            // Resync: this bit starts a fresh frame.
            cap_clr = 1'b1;
            cap_we  = 1'b1;
            cnt_nxt = CNT_W'(1);
            err_c   = 1'b1;
          end else begin
            cap_we  = 1'b1;
            cap_idx = IDX_W'(bit_pos(32'(cnt_q), LSB_FIRST, WIDTH));
            cnt_nxt = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_CNT) begin
`ifdef WORD_DESER_PARITY_EN
              state_nxt = PARITY;
`else
              state_nxt = DONE;
`endif
            end
          end
        end
      end

`ifdef WORD_DESER_PARITY_EN
      PARITY: begin
        if (accept_c) begin
          if (ser_first) begin
            cap_clr   = 1'b1;
            cap_we    = 1'b1;
            cnt_nxt   = CNT_W'(1);
            err_c     = 1'b1;
            state_nxt = SHIFT;
          end else if ((^cap_q) ^ ser_data) begin
            err_c     = 1'b1;
            cnt_nxt   = '0;
            state_nxt = IDLE;
          end else begin
            state_nxt = DONE;
          end
        end
      end
`endif

      DONE: begin
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end

      default: begin
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  // State, counter and registered outputs (decoded from next state).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      word_out  <= '0;
      load      <= 1'b0;
      busy      <= 1'b0;
      ser_ready <= 1'b1;
      frame_err <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      cnt_q     <= cnt_nxt;
      load      <= (state_nxt == DONE);
      busy      <= (state_nxt != IDLE);
      ser_ready <= (state_nxt != DONE);
      frame_err <= err_c;
      // From SHIFT the last bit lands this edge; from PARITY the word is complete.
      if (state_nxt == DONE && state_q != DONE)
        word_out <= (state_q == SHIFT) ? cap_nxt : cap_q;
    end
  end

endmodule

// File: tb/tb_word_deserializer.sv
// Directed self-checking bench for word_deserializer: an LSB-first and an
// MSB-first instance share one serial stream; the MSB-first word is the
// bit reversal of the LSB-first one.
module tb_word_deserializer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ser_valid, ser_data, ser_first;
  logic        ser_ready, load, busy, frame_err;
  logic [15:0] word_out;
  logic        m_ser_ready, m_load, m_busy, m_frame_err;
  logic [15:0] m_word_out;

  int checks = 0;
  int errors = 0;
  int load_cnt = 0;
  int err_cnt = 0;
  int snap_load, snap_err;

  always #5 clk = ~clk;

  word_deserializer #(.WIDTH(16), .LSB_FIRST(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .ser_valid(ser_valid), .ser_data(ser_data),
    .ser_first(ser_first), .ser_ready(ser_ready), .word_out(word_out),
    .load(load), .busy(busy), .frame_err(frame_err)
  );

  word_deserializer #(.WIDTH(16), .LSB_FIRST(1'b0)) dut_m (
    .clk(clk), .rst_n(rst_n), .ser_valid(ser_valid), .ser_data(ser_data),
    .ser_first(ser_first), .ser_ready(m_ser_ready), .word_out(m_word_out),
    .load(m_load), .busy(m_busy), .frame_err(m_frame_err)
  );

  always @(negedge clk) begin
    if (load) load_cnt++;
    if (frame_err) err_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One offered beat; returns 1 ns after the sampling edge.
  task automatic beat(input logic d, input logic f);
    ser_valid = 1'b1;
    ser_data  = d;
    ser_first = f;
    @(posedge clk);
    #1;
    ser_valid = 1'b0;
    ser_first = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  // Bits from..15 of w, LSB of w first; ser_first on bit 0; parity if built in.
  task automatic send_tail(input logic [15:0] w, input int from);
    for (int i = from; i < 16; i++) beat(w[i], i == 0);
`ifdef WORD_DESER_PARITY_EN
    beat(^w, 1'b0);
`endif
  endtask

  // After the last beat: DONE cycle, then back to IDLE.
  task automatic check_done(input string tag, input logic [15:0] exp, input logic [15:0] exp_m);
    check({tag, "_load"}, 32'(load), 32'd1);
    check({tag, "_word"}, 32'(word_out), 32'(exp));
    check({tag, "_word_m"}, 32'(m_word_out), 32'(exp_m));
    check({tag, "_ready_done"}, 32'(ser_ready), 32'd0);
    idle_cycle();
    check({tag, "_load_gone"}, 32'(load), 32'd0);
    check({tag, "_ready_idle"}, 32'(ser_ready), 32'd1);
    check({tag, "_busy_idle"}, 32'(busy), 32'd0);
    check({tag, "_word_held"}, 32'(word_out), 32'(exp));
  endtask

  initial begin
    rst_n     = 1'b0;
    ser_valid = 1'b0;
    ser_data  = 1'b0;
    ser_first = 1'b0;
    #22 rst_n = 1'b1;
    idle_cycle();

    // Reset / idle state
    check("rst_word", 32'(word_out), 32'h0);
    check("rst_load", 32'(load), 32'd0);
    check("rst_ready", 32'(ser_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(frame_err), 32'd0);
    check("rst_word_m", 32'(m_word_out), 32'h0);

    // Normal frame 0xA5C3 (MSB-first instance sees the bit reversal 0xC3A5)
    snap_load = load_cnt;
    beat(1'b1, 1'b1);
    check("a5c3_busy", 32'(busy), 32'd1);
    check("a5c3_noload", 32'(load), 32'd0);
    send_tail(16'hA5C3, 1);
    check_done("a5c3", 16'hA5C3, 16'hC3A5);
    check("a5c3_one_load", 32'(load_cnt - snap_load), 32'd1);

    // Symmetric stream 0x8001
    send_tail(16'h8001, 0);
    check_done("8001", 16'h8001, 16'h8001);

    // Resync: 7 bits, then a new frame 0x1234 (reversal 0x2C48)
    snap_err = err_cnt;
    for (int i = 0; i < 7; i++) beat(1'b1, i == 0);
    beat(1'b0, 1'b1);
    check("resync_err", 32'(frame_err), 32'd1);
    check("resync_busy", 32'(busy), 32'd1);
    send_tail(16'h1234, 1);
    check_done("resync", 16'h1234, 16'h2C48);
    check("resync_one_err", 32'(err_cnt - snap_err), 32'd1);

    // Stray bit in IDLE
    beat(1'b1, 1'b0);
    check("stray_err", 32'(frame_err), 32'd1);
    check("stray_busy", 32'(busy), 32'd0);
    idle_cycle();
    check("stray_err_gone", 32'(frame_err), 32'd0);
    check("stray_word", 32'(word_out), 32'h1234);

    // Async reset mid-frame, then a full 0xFFFF frame
    snap_load = load_cnt;
    for (int i = 0; i < 10; i++) beat(1'b1, i == 0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_word", 32'(word_out), 32'h0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_ready", 32'(ser_ready), 32'd1);
    #3 rst_n = 1'b1;
    idle_cycle();
    check("arst_noload", 32'(load_cnt - snap_load), 32'd0);
    send_tail(16'hFFFF, 0);
    check_done("ffff", 16'hFFFF, 16'hFFFF);

`ifdef WORD_DESER_PARITY_EN
    // Good parity: 0x0003 with parity 0
    for (int i = 0; i < 16; i++) beat(i < 2, i == 0);
    check("par_ok_wait", 32'(load), 32'd0);
    beat(1'b0, 1'b0);
    check_done("par_ok", 16'h0003, 16'hC000);

    // Bad parity: 0x0001 with parity 0
    snap_load = load_cnt;
    for (int i = 0; i < 16; i++) beat(i == 0, i == 0);
    beat(1'b0, 1'b0);
    check("par_bad_err", 32'(frame_err), 32'd1);
    check("par_bad_load", 32'(load), 32'd0);
    check("par_bad_busy", 32'(busy), 32'd0);
    check("par_bad_word", 32'(word_out), 32'h0003);
    idle_cycle();
    check("par_bad_noload", 32'(load_cnt - snap_load), 32'd0);
`endif

    repeat (2) idle_cycle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/word_deserializer.md
Name: word_deserializer

Overview:
Serial-to-parallel producer for the 16-bit register's parallel in/load interface.
- Accepts one bit per handshake, assembles a WIDTH-bit word and pulses `load` with the word on `word_out`.
- Drives a downstream 16-bit Register directly: `word_out` connects to `in`, `load` connects to `load`.
- Sits between serial peripherals (keyboard/link input) and the CPU-visible register file.

Parameters:
- WIDTH, 16: word width in bits; legal range 2..32.
- LSB_FIRST, 1: 1 = first accepted bit lands in bit 0; 0 = first bit lands in bit WIDTH-1.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- ser_valid  input  1  serial bit offered this cycle.
- ser_data  input  1  serial bit value.
- ser_first  input  1  marks the first bit of a frame; sampled only on an accepted beat.
- ser_ready  output  1  block can accept a bit this cycle.
- word_out  output  WIDTH  last completed word; held stable between loads.
- load  output  1  one-cycle pulse; `word_out` is valid and new in that cycle.
- busy  output  1  frame in progress (state != IDLE).
- frame_err  output  1  one-cycle pulse on a framing violation.

Behaviour:
- Accepted beat: `ser_valid && ser_ready` at a rising clk edge.
- Reset (`rst_n` = 0): immediate, regardless of clock.
  - State returns to IDLE; the internal shift register and bit counter clear.
  - `word_out` = 0; `load`, `busy` and `frame_err` = 0; `ser_ready` = 1.
  - Reset mid-frame discards partial bits and produces no `load`.
- States: IDLE, SHIFT, DONE, plus PARITY when the optional feature is enabled.
- IDLE:
  - Accepted beat with `ser_first` = 1: store the bit at position 0 (LSB_FIRST=1) or WIDTH-1 (LSB_FIRST=0); counter = 1; go to SHIFT.
  - Accepted beat with `ser_first` = 0: bit dropped, `frame_err` pulses next cycle, stay IDLE.
- SHIFT:
  - Accepted beat with `ser_first` = 0: store the bit at the counter position (mirrored if LSB_FIRST=0); counter++.
  - On the beat that makes counter == WIDTH: go to DONE, or to PARITY if enabled.
  - Accepted beat with `ser_first` = 1: resync. Partial word discarded, this bit becomes bit 0 of a new frame, counter = 1, `frame_err` pulses, stay SHIFT.
  - `ser_valid` low: hold state indefinitely; there is no timeout.
- DONE (exactly one cycle):
  - `word_out` <= assembled word, registered on entry.
  - `load` = 1 and `ser_ready` = 0 during this cycle.
  - Next state is IDLE.
- Latency: `load` is high in the cycle immediately after the edge that accepted the last data bit.
- Back-to-back frames: minimum gap is the single DONE cycle, since `ser_ready` = 0 there.
- `ser_ready` = 1 in every state except DONE.
- `busy` = 1 in SHIFT, PARITY and DONE.
- `word_out` changes only on entry to DONE.
- Counter width: $clog2(WIDTH+1); it never wraps, because DONE is entered at WIDTH.

Optional Feature:
WORD_DESER_PARITY_EN.
- Defined:
  - After WIDTH data bits, the PARITY state accepts one more beat: an even-parity bit, so the XOR of data and parity must be 0.
  - Match: go to DONE as normal.
  - Mismatch: no `load`, `word_out` unchanged, `frame_err` pulses, go to IDLE.
  - `ser_first` = 1 in PARITY: resync exactly as in SHIFT.
  - Latency becomes WIDTH+1 beats plus 1 cycle.
- Undefined: the PARITY state and its logic are absent; behaviour is as described above.

Decomposition:
- Shared package `deser_pkg`:
  - state enum `deser_state_t` {IDLE, SHIFT, PARITY, DONE};
  - constant WORD_W = 16;
  - function `bit_pos(cnt, lsb_first)` returning the storage index.
- One natural sub-module, `shift_capture`:
  - WIDTH-bit register with per-bit write enable, clear, and index input;
  - purely sequential, no FSM.

Test Plan:
- Reset/idle: hold `rst_n` low, then release; send nothing. Expect `word_out` = 16'h0000, `load` = 0, `ser_ready` = 1, `busy` = 0.
- Normal frame: send 16'hA5C3 LSB first, `ser_first` on bit 0, `ser_valid` continuous. Expect `load` high exactly one cycle, one cycle after the 16th beat; `word_out` = 16'hA5C3 and held thereafter.
- MSB-first build: build with LSB_FIRST = 0 and send the bit stream of 16'h8001 MSB first. Expect `word_out` = 16'h8001.
- Resync and stray bit:
  - Send 7 bits, then assert `ser_first` with a new 16'h1234 frame. Expect one `frame_err` pulse and `word_out` = 16'h1234.
  - In IDLE, a beat with `ser_first` = 0 gives a `frame_err` pulse and no state change.
- Async reset mid-frame: assert `rst_n` low asynchronously after 10 bits; then send 16'hFFFF. Expect no `load` from the partial frame, and `word_out` = 16'hFFFF after the full frame.
- Parity (WORD_DESER_PARITY_EN):
  - 16'h0003 with parity 0: `load`, `word_out` = 16'h0003.
  - 16'h0001 with parity 0: `frame_err` pulse, no `load`, `word_out` unchanged.
